tensor_core_instruction_receiver: RTL and testbench

//  Tensor-core-side endpoint of the 16-bit instruction bus driven by the memory controller.

---
 rtl/tensor_core_instruction_receiver_pkg.sv | 37 +++
 rtl/tensor_core_instruction_receiver_if.sv | 30 +++
 rtl/tensor_core_instruction_receiver_mac_sequencer.sv | 108 ++++++++++
 rtl/tensor_core_instruction_receiver.sv | 149 ++++++++++++++
 tb/tb_tensor_core_instruction_receiver.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/tensor_core_instruction_receiver_pkg.sv
// Shared encodings for the tensor-core instruction bus: opcode/select values (also used by
// the memory controller), FSM state codes, instruction field positions and the saturator.
`ifndef TENSOR_CORE_BUS_DEFINES
`define TENSOR_CORE_BUS_DEFINES
`define TC_OP_NOP     2'b00
`define TC_OP_OPERATE 2'b01
`define TC_OP_BURST   2'b10
`define TC_OP_RESET   2'b11
`define TC_SEL_READ   2'b00
`define TC_SEL_WRITE  2'b01
`define TC_SEL_RW     2'b10
`define TC_SEL_RSVD   2'b11
`endif

package tensor_core_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_BURST   = 2'd1;
  localparam logic [1:0] ST_COMPUTE = 2'd2;

  localparam int F_OP_LSB  = 0;
  localparam int F_SEL_LSB = 2;
  localparam int F_CNT_LSB = 4;
  localparam int F_RSV_LSB = 12;

  // Clamp a signed value into the range of a signed 'width'-bit number.
  function automatic logic signed [31:0] saturate(input logic signed [31:0] v, input int width);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (width - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (width - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/tensor_core_instruction_receiver_if.sv
// Link between the receiver (register-file owner) and the MAC sequencer.
interface tensor_core_instruction_receiver_if #(
  parameter int AB_W       = 5,
  parameter int C_W        = 4,
  parameter int DATA_WIDTH = 8
);
  // start: one-cycle request, only raised while busy is low; the sequencer raises busy on
  // the following cycle. done is high for exactly the last busy cycle. Operand reads are
  // combinational (a_idx/b_idx -> a_val/b_val); c_we writes c_data into C[c_idx] at the edge.
  logic                          start;
  logic                          busy;
  logic                          done;
  logic [AB_W-1:0]               a_idx;
  logic [AB_W-1:0]               b_idx;
  logic signed [DATA_WIDTH-1:0]  a_val;
  logic signed [DATA_WIDTH-1:0]  b_val;
  logic                          c_we;
  logic [C_W-1:0]                c_idx;
  logic [DATA_WIDTH-1:0]         c_data;

  modport master (
    output start, a_val, b_val,
    input  busy, done, a_idx, b_idx, c_we, c_idx, c_data
  );

  modport slave (
    input  start, a_val, b_val,
    output busy, done, a_idx, b_idx, c_we, c_idx, c_data
  );
endinterface

// File: rtl/tensor_core_instruction_receiver_mac_sequencer.sv
// Sequential matrix multiply: one MAC per cycle over i/j/k (k fastest), saturated C writes.
module tensor_core_mac_sequencer
  import tensor_core_pkg::*;
#(
  parameter int DIM        = 3,
  parameter int DATA_WIDTH = 8,
  parameter int AB_W       = 5,
  parameter int C_W        = 4
) (
  input  logic clk,
  input  logic rst,
  tensor_core_instruction_receiver_if.slave mac
);

  localparam int NELEM = DIM * DIM;
  localparam int CNT_W = (DIM > 1) ? $clog2(DIM) : 1;
  localparam int ACC_W = 2 * DATA_WIDTH + $clog2(DIM);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIM - 1);

  logic                     run_q, run_d;
  logic                     drain_q, drain_d;
  logic [CNT_W-1:0]         i_q, i_d, j_q, j_d, k_q, k_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic                     c_pend_q, c_pend_d;
  logic [C_W-1:0]           c_idx_q, c_idx_d;

  logic signed [2*DATA_WIDTH-1:0] prod;
  logic signed [ACC_W-1:0]        prod_ext;
  logic signed [ACC_W-1:0]        sum;

  assign mac.a_idx  = AB_W'(int'(i_q) * DIM + int'(k_q));
  assign mac.b_idx  = AB_W'(NELEM + int'(k_q) * DIM + int'(j_q));
  assign mac.busy   = run_q;
  assign mac.done   = drain_q;
  assign mac.c_we   = c_pend_q;
  assign mac.c_idx  = c_idx_q;
  // The finished dot product is written one cycle after its last MAC, from acc_q.
  assign mac.c_data = DATA_WIDTH'(saturate(32'(acc_q), DATA_WIDTH));

  always_comb begin
    prod     = mac.a_val * mac.b_val;
    prod_ext = ACC_W'(prod);
    sum      = ((k_q == '0) ? '0 : acc_q) + prod_ext;
  end

  always_comb begin
    run_d    = run_q;
    drain_d  = drain_q;
    i_d      = i_q;
    j_d      = j_q;
    k_d      = k_q;
    acc_d    = acc_q;
    c_pend_d = 1'b0;
    c_idx_d  = c_idx_q;
    if (drain_q) begin
      run_d   = 1'b0;
      drain_d = 1'b0;
    end else if (run_q) begin
      acc_d = sum;
      if (k_q == LAST) begin
        k_d      = '0;
        c_pend_d = 1'b1;
        c_idx_d  = C_W'(int'(i_q) * DIM + int'(j_q));
        if (j_q == LAST) begin
          j_d = '0;
          if (i_q == LAST) begin
            i_d     = '0;
            drain_d = 1'b1;
          end else begin
            i_d = i_q + 1'b1;
          end
        end else begin
          j_d = j_q + 1'b1;
        end
      end else begin
        k_d = k_q + 1'b1;
      end
    end else if (mac.start) begin
      run_d = 1'b1;
      i_d   = '0;
      j_d   = '0;
      k_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      run_q    <= 1'b0;
      drain_q  <= 1'b0;
      i_q      <= '0;
      j_q      <= '0;
      k_q      <= '0;
      acc_q    <= '0;
      c_pend_q <= 1'b0;
      c_idx_q  <= '0;
    end else begin
      run_q    <= run_d;
      drain_q  <= drain_d;
      i_q      <= i_d;
      j_q      <= j_d;
      k_q      <= k_d;
      acc_q    <= acc_d;
      c_pend_q <= c_pend_d;
      c_idx_q  <= c_idx_d;
    end
  end

endmodule

// File: rtl/tensor_core_instruction_receiver.sv
// Tensor-core endpoint of the 16-bit instruction bus: word decode, burst FSM, A/B/C register
// files; the multiply itself runs in tensor_core_mac_sequencer.
module tensor_core_instruction_receiver
  import tensor_core_pkg::*;
#(
  parameter int DIM         = 3,
  parameter int DATA_WIDTH  = 8,
  parameter int COUNT_WIDTH = 8
) (
  input  logic                  clock_in,
  input  logic                  reset_in,
  input  logic [15:0]           current_tensor_core_instruction,
  output logic [DATA_WIDTH-1:0] tensor_core_controller_output,
  output logic                  busy,
  output logic                  error
);

  localparam int NELEM   = DIM * DIM;
  localparam int NAB     = 2 * NELEM;
  localparam int AB_W    = $clog2(NAB);
  localparam int C_W     = $clog2(NELEM);
  localparam int BEATS_W = COUNT_WIDTH + 1;

  logic [1:0]             state_q, state_d;
  logic [1:0]             sel_q, sel_d;
  logic [BEATS_W-1:0]     beats_q, beats_d;
  logic [AB_W-1:0]        wr_ptr_q, wr_ptr_d;
  logic [C_W-1:0]         rd_ptr_q, rd_ptr_d;
  logic                   error_q, error_d;
  logic [DATA_WIDTH-1:0]  ab_q [NAB];
  logic [DATA_WIDTH-1:0]  c_q  [NELEM];

  logic [15:0]            word;
  logic [1:0]             opcode;
  logic [1:0]             sel_f;
  logic [COUNT_WIDTH-1:0] cnt_f;
  logic [3:0]             rsv_f;
  logic                   soft_rst;
  logic                   rst_all;
  logic                   rd_beat;
  logic                   wr_beat;
  logic [AB_W-1:0]        wr_ptr_p1;
  logic                   mac_start;

  tensor_core_instruction_receiver_if #(
    .AB_W       (AB_W),
    .C_W        (C_W),
    .DATA_WIDTH (DATA_WIDTH)
  ) mac_bus ();

  tensor_core_mac_sequencer #(
    .DIM        (DIM),
    .DATA_WIDTH (DATA_WIDTH),
    .AB_W       (AB_W),
    .C_W        (C_W)
  ) u_mac (
    .clk (clock_in),
    .rst (rst_all),
    .mac (mac_bus.slave)
  );

  assign word   = current_tensor_core_instruction;
  assign opcode = word[F_OP_LSB +: 2];
  assign sel_f  = word[F_SEL_LSB +: 2];
  assign cnt_f  = word[F_CNT_LSB +: COUNT_WIDTH];
  assign rsv_f  = word[15:F_RSV_LSB];

  // Inside a burst every word is payload, so RESET is only recognised outside BURST.
  assign soft_rst = (state_q != ST_BURST) && (opcode == `TC_OP_RESET);
  assign rst_all  = reset_in || soft_rst;

  assign rd_beat   = (state_q == ST_BURST) && ((sel_q == `TC_SEL_READ) || (sel_q == `TC_SEL_RW));
  assign wr_beat   = (state_q == ST_BURST) && ((sel_q == `TC_SEL_WRITE) || (sel_q == `TC_SEL_RW));
  assign wr_ptr_p1 = wr_ptr_q + 1'b1;

  assign mac_bus.start = mac_start;
  assign mac_bus.a_val = ab_q[mac_bus.a_idx];
  assign mac_bus.b_val = ab_q[mac_bus.b_idx];

  assign tensor_core_controller_output = rd_beat ? c_q[rd_ptr_q] : '0;
  assign busy  = mac_bus.busy;
  assign error = error_q;

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    beats_d   = beats_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    error_d   = error_q;
    mac_start = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (opcode == `TC_OP_OPERATE) begin
          state_d   = ST_COMPUTE;
          mac_start = 1'b1;
        end else if (opcode == `TC_OP_BURST) begin
          if ((sel_f == `TC_SEL_RSVD) || (rsv_f != 4'd0)) begin
            error_d = 1'b1;
          end else begin
            state_d  = ST_BURST;
            sel_d    = sel_f;
            // A zero count encodes the longest burst, 2^COUNT_WIDTH beats.
            beats_d  = (cnt_f == '0) ? {1'b1, {COUNT_WIDTH{1'b0}}} : {1'b0, cnt_f};
            wr_ptr_d = '0;
            rd_ptr_d = '0;
          end
        end
      end
      ST_BURST: begin
        if (wr_beat) wr_ptr_d = (wr_ptr_q == AB_W'(NAB - 2)) ? '0 : wr_ptr_q + AB_W'(2);
        if (rd_beat) rd_ptr_d = (rd_ptr_q == C_W'(NELEM - 1)) ? '0 : rd_ptr_q + 1'b1;
        beats_d = beats_q - 1'b1;
        if (beats_q == BEATS_W'(1)) state_d = ST_IDLE;
      end
      ST_COMPUTE: begin
        if ((opcode == `TC_OP_OPERATE) || (opcode == `TC_OP_BURST)) error_d = 1'b1;
        if (mac_bus.done) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock_in) begin
    if (rst_all) begin
      state_q  <= ST_IDLE;
      sel_q    <= `TC_SEL_READ;
      beats_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      error_q  <= 1'b0;
      for (int e = 0; e < NAB; e++) ab_q[e] <= '0;
      for (int e = 0; e < NELEM; e++) c_q[e] <= '0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      beats_q  <= beats_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      error_q  <= error_d;
      if (wr_beat) begin
        ab_q[wr_ptr_q]  <= word[2*DATA_WIDTH-1 -: DATA_WIDTH];
        ab_q[wr_ptr_p1] <= word[DATA_WIDTH-1:0];
      end
      if (mac_bus.c_we) c_q[mac_bus.c_idx] <= mac_bus.c_data;
    end
  end

endmodule

// File: tb/tb_tensor_core_instruction_receiver.sv
// Directed + randomized bench for tensor_core_instruction_receiver against a matrix-level model.
module tb_tensor_core_instruction_receiver;

  localparam logic [1:0] SEL_RD = 2'b00;
  localparam logic [1:0] SEL_WR = 2'b01;
  localparam logic [1:0] SEL_RW = 2'b10;
  localparam logic [15:0] W_NOP = 16'h0000;
  localparam logic [15:0] W_OPERATE = 16'h0001;
  localparam logic [15:0] W_RESET = 16'h0003;

  // clock / reset
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] instr = 16'h0000;
  logic [7:0]  dout;
  logic        busy;
  logic        err;

  always #5 clk = ~clk;

  tensor_core_instruction_receiver dut (
    .clock_in                        (clk),
    .reset_in                        (rst),
    .current_tensor_core_instruction (instr),
    .tensor_core_controller_output   (dout),
    .busy                            (busy),
    .error                           (err)
  );

  // reference model: flat operand memory (A then B) and result matrix
  int total = 0;
  int bad = 0;
  int ab[18];
  int cm[9];
  logic [7:0] src_q[$];

  initial begin
    #500000;
    $display("FAIL watchdog: run did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic void model_clear();
    for (int e = 0; e < 18; e++) ab[e] = 0;
    for (int e = 0; e < 9; e++) cm[e] = 0;
  endfunction

  function automatic void model_compute();
    int s;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) begin
        s = 0;
        for (int k = 0; k < 3; k++) s += ab[i*3 + k] * ab[9 + k*3 + j];
        cm[i*3 + j] = (s > 127) ? 127 : ((s < -128) ? -128 : s);
      end
  endfunction

  function automatic logic [15:0] hdr(input logic [1:0] sel, input int n);
    logic [7:0] cnt;
    cnt = n[7:0];
    return {4'b0000, cnt, sel, 2'b10};
  endfunction

  // driver tasks
  task automatic step(input logic [15:0] w);
    instr = w;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    step(W_NOP);
    rst = 1'b0;
    model_clear();
  endtask

  task automatic burst(input logic [1:0] sel, input int n, input string tag);
    int beats;
    logic [7:0] hi, lo;
    beats = (n == 0) ? 256 : n;
    step(hdr(sel, n));
    for (int m = 0; m < beats; m++) begin
      hi = 8'($urandom);
      lo = 8'($urandom);
      if (sel != SEL_RD) begin
        if (src_q.size() > 0) hi = src_q.pop_front();
        if (src_q.size() > 0) lo = src_q.pop_front();
      end
      instr = {hi, lo};
      @(negedge clk);
      if (sel == SEL_WR) check({tag, "_wr_out0"}, $signed(dout), 0);
      else check(tag, $signed(dout), cm[m % 9]);
      @(posedge clk);
      #1;
      if (sel != SEL_RD) begin
        ab[(2*m) % 18]     = int'($signed(hi));
        ab[(2*m + 1) % 18] = int'($signed(lo));
      end
    end
  endtask

  task automatic operate(input int inject_at, input logic [15:0] inj, output int cnt);
    step(W_OPERATE);
    cnt = 0;
    while (busy === 1'b1 && cnt < 200) begin
      cnt++;
      step((cnt == inject_at) ? inj : W_NOP);
    end
  endtask

  task automatic fill_random(input int nbytes, input int lo, input int hi);
    src_q.delete();
    for (int b = 0; b < nbytes; b++) src_q.push_back(8'($urandom_range(hi - lo) + lo));
  endtask

  // stimulus
  int cnt;
  initial begin
    model_clear();
    step(W_NOP);
    step(W_NOP);
    rst = 1'b0;
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    check("rst_out", $signed(dout), 0);
    burst(SEL_RD, 9, "rst_read");

    // 1..18 -> A = 1..9, B = 10..18
    src_q.delete();
    for (int b = 1; b <= 18; b++) src_q.push_back(8'(b));
    burst(SEL_WR, 9, "seq_write");
    operate(-1, W_NOP, cnt);
    check("seq_busy_len", cnt, 28);
    model_compute();
    burst(SEL_RD, 9, "seq_read");

    // identity A, small B; read wraps on the 10th beat
    src_q.delete();
    for (int e = 0; e < 9; e++) src_q.push_back((e % 4 == 0) ? 8'd1 : 8'd0);
    for (int e = 0; e < 9; e++) src_q.push_back(8'($urandom_range(40) - 20));
    burst(SEL_WR, 9, "id_write");
    operate(-1, W_NOP, cnt);
    check("id_busy_len", cnt, 28);
    model_compute();
    burst(SEL_RD, 10, "id_read_wrap");

    // -I times all -128 saturates to +127
    src_q.delete();
    for (int e = 0; e < 9; e++) src_q.push_back((e % 4 == 0) ? 8'hFF : 8'h00);
    for (int e = 0; e < 9; e++) src_q.push_back(8'h80);
    burst(SEL_WR, 9, "neg_write");
    operate(-1, W_NOP, cnt);
    model_compute();
    burst(SEL_RD, 9, "neg_sat_read");

    // random full-range operands loaded by read+write bursts streaming the previous C
    for (int t = 0; t < 3; t++) begin
      fill_random((t == 2) ? 20 : 18, 0, 255);
      burst(SEL_RW, (t == 2) ? 10 : 9, "rw_old_c");
      operate(-1, W_NOP, cnt);
      check("rnd_busy_len", cnt, 28);
      model_compute();
      burst(SEL_RD, 9, "rnd_read");
    end
    burst(SEL_RD, 0, "read_n0");
    check("n0_idle_err", err, 0);

    // BURST header during COMPUTE: flagged, result unaffected
    fill_random(18, 0, 255);
    burst(SEL_WR, 9, "viol_write");
    operate(5, hdr(SEL_WR, 1), cnt);
    check("viol_busy_len", cnt, 28);
    check("viol_err", err, 1);
    model_compute();
    burst(SEL_RD, 9, "viol_read");
    check("viol_err_sticky", err, 1);
    pulse_reset();
    check("viol_err_clr", err, 0);

    // OPERATE during COMPUTE is also a violation
    operate(3, W_OPERATE, cnt);
    check("op_in_compute_len", cnt, 28);
    check("op_in_compute_err", err, 1);
    pulse_reset();

    // reserved select and nonzero upper bits in IDLE: error, FSM stays IDLE
    step(hdr(2'b11, 3));
    check("rsvd_sel_err", err, 1);
    check("rsvd_sel_busy", busy, 0);
    operate(-1, W_NOP, cnt);
    check("rsvd_sel_idle", cnt, 28);
    pulse_reset();
    step(16'h1000 | hdr(SEL_WR, 2));
    check("rsv_bits_err", err, 1);
    operate(-1, W_NOP, cnt);
    check("rsv_bits_idle", cnt, 28);
    pulse_reset();

    // RESET word on COMPUTE cycle 10
    fill_random(18, 0, 255);
    burst(SEL_WR, 9, "mid_write");
    operate(-1, W_NOP, cnt);
    operate(10, W_RESET, cnt);
    check("reset_word_len", cnt, 10);
    check("reset_word_busy", busy, 0);
    check("reset_word_err", err, 0);
    model_clear();
    burst(SEL_RD, 9, "reset_word_c0");
    operate(-1, W_NOP, cnt);
    check("reset_word_ab0_len", cnt, 28);
    burst(SEL_RD, 9, "reset_word_ab0");

    // reset_in on write beat 4
    fill_random(18, 0, 255);
    burst(SEL_WR, 9, "pre_write");
    operate(-1, W_NOP, cnt);
    model_compute();
    step(hdr(SEL_WR, 9));
    for (int m = 0; m < 3; m++) step(16'($urandom));
    rst = 1'b1;
    step(16'($urandom));
    rst = 1'b0;
    model_clear();
    check("rst_beat_busy", busy, 0);
    check("rst_beat_out", $signed(dout), 0);
    burst(SEL_RD, 9, "rst_beat_c0");
    operate(-1, W_NOP, cnt);
    check("rst_beat_len", cnt, 28);
    burst(SEL_RD, 9, "rst_beat_ab0");

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
